// File: rtl/dot_product_mac.sv
// Sequential multiply-accumulate stage: one (a, b) pair per handshake, an N-cycle
// shift-add multiply, then accumulation until the pair flagged last.
module dot_product_mac #(
  parameter int N     = 8,
  parameter int ACC_W = 2*N+4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

  state_t           state, state_next;
  logic [2*N-1:0]   mcand;
  logic [2*N-1:0]   product;
  logic [N-1:0]     mplier;
  logic [CW-1:0]    count;
  logic             last;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             valid;
  logic [ACC_W:0]   acc_sum;

  // Extra top bit of the sum captures the carry-out that drives the sticky overflow.
  assign acc_sum = {1'b0, acc} + {{(ACC_W+1-2*N){1'b0}}, product};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)                state_next = MUL;
      MUL:  if (count == CW'(N-1))       state_next = ACC;
      ACC:  state_next = last ? OUT : IDLE;
      OUT:  if (out_ready)               state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      product <= '0;
      mplier  <= '0;
      count   <= '0;
      last    <= 1'b0;
      acc     <= '0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand   <= {{N{1'b0}}, in_a};
          mplier  <= in_b;
          last    <= in_last;
          product <= '0;
          count   <= '0;
        end
        MUL: begin
          if (mplier[0]) product <= product + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        ACC: begin
          acc <= acc_sum[ACC_W-1:0];
          if (acc_sum[ACC_W]) ovf <= 1'b1;
          if (last) valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          acc   <= '0;
          ovf   <= 1'b0;
          valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst_n so it reads low for the whole reset pulse.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = valid;
  assign out_sum   = valid ? acc : '0;
  assign out_ovf   = valid & ovf;

endmodule

// File: tb/tb_dot_product_mac.sv
// Randomized self-checking bench for dot_product_mac against an arithmetic reference model.
module tb_dot_product_mac;
  localparam int N     = 8;
  localparam int ACC_W = 2*N+4;
  localparam longint MOD = 64'd1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  dot_product_mac #(.N(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int     pass_count  = 0;
  int     check_count = 0;
  int     cyc         = 0;
  int     acc_q[$];
  longint model_acc   = 0;
  bit     model_ovf   = 1'b0;

  always @(posedge clk) begin
    if (in_valid && in_ready) acc_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  // Operands must be ignored outside the accept cycle, so they are randomized whenever not accepted.
  always @(negedge clk) begin
    if (!in_ready) begin
      in_a    = N'($urandom);
      in_b    = N'($urandom);
      in_last = 1'($urandom);
    end
  end

  task automatic check_value(input string tag, input longint obs, input longint exp);
    check_count++;
    if (obs == exp) pass_count++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_add(input longint a, input longint b);
    model_acc = model_acc + a * b;
    if (model_acc >= MOD) begin
      model_ovf = 1'b1;
      model_acc = model_acc - MOD;
    end
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic l, input bit keep);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    while (!in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check_value("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    in_a = a; in_b = b; in_last = l;
    model_add(a, b);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic collect(input int delay, output int seen);
    int t = 0;
    seen = 0;
    @(negedge clk);
    while (!out_valid && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      check_value("result_timeout", 0, 1);
      return;
    end
    seen = cyc;
    $display("result sum=%0d ovf=%0d (model %0d/%0d)", out_sum, out_ovf, model_acc, model_ovf);
    check_value("sum", out_sum, model_acc);
    check_value("ovf", out_ovf, model_ovf);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check_value("hold_valid", out_valid, 1);
      check_value("hold_sum", out_sum, model_acc);
      check_value("hold_ovf", out_ovf, model_ovf);
      check_value("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    model_acc = 0;
    model_ovf = 1'b0;
    @(negedge clk);
    check_value("post_valid", out_valid, 0);
    check_value("post_sum", out_sum, 0);
    check_value("post_ovf", out_ovf, 0);
    check_value("post_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen, n0, len, dly;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_in_ready", in_ready, 0);
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_out_sum", out_sum, 0);
    check_value("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    #1 check_value("idle_in_ready", in_ready, 1);

    // Two-pair dot product: latency and accept count.
    n0 = acc_q.size();
    send(8'd3, 8'd5, 1'b0, 1'b0);
    send(8'd4, 8'd6, 1'b1, 1'b0);
    collect(0, seen);
    check_value("t1_accepts", acc_q.size() - n0, 2);
    if (acc_q.size() > n0) check_value("t1_latency", seen - acc_q[n0], 2*(N+2));

    // Largest operands: no wrap at 16 pairs, wrap at 17.
    for (int i = 0; i < 16; i++) send(8'd255, 8'd255, i == 15, 1'b0);
    collect(0, seen);
    for (int i = 0; i < 17; i++) send(8'd255, 8'd255, i == 16, 1'b0);
    collect(0, seen);

    // Backpressure with in_valid held high during OUT, then a fresh accumulation.
    send(8'd9, 8'd11, 1'b1, 1'b1);
    n0 = acc_q.size();
    collect(5, seen);
    check_value("t3_no_accept", acc_q.size() - n0, 0);
    send(8'd2, 8'd2, 1'b1, 1'b0);
    collect(0, seen);

    // Zero and unit operands.
    send(8'd0, 8'd255, 1'b1, 1'b0); collect(0, seen);
    send(8'd255, 8'd0, 1'b1, 1'b0); collect(0, seen);
    send(8'd1, 8'd1, 1'b1, 1'b0);   collect(0, seen);

    // Reset mid-MUL of the second pair discards the partial sum.
    send(8'd9, 8'd9, 1'b0, 1'b0);
    send(8'd3, 8'd200, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_value("abort_in_ready", in_ready, 0);
    check_value("abort_out_valid", out_valid, 0);
    check_value("abort_out_sum", out_sum, 0);
    check_value("abort_out_ovf", out_ovf, 0);
    model_acc = 0; model_ovf = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    send(8'd7, 8'd7, 1'b1, 1'b0);
    collect(0, seen);

    // Operands scrambled after accept; back-to-back pairs with in_valid held high.
    send(8'd10, 8'd10, 1'b1, 1'b0);
    collect(0, seen);
    n0 = acc_q.size();
    for (int i = 0; i < 4; i++) send(N'($urandom), N'($urandom), i == 3, 1'b1);
    in_valid = 1'b0;
    collect(1, seen);
    check_value("b2b_count", acc_q.size() - n0, 4);
    for (int i = 1; i < 4; i++)
      if (acc_q.size() > n0 + i) check_value("b2b_spacing", acc_q[n0+i] - acc_q[n0+i-1], N+2);

    // Randomized dot products of random length and output stall.
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 6);
      dly = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) send(N'($urandom), N'($urandom), i == len-1, 1'($urandom));
      collect(dly, seen);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
